// File: rtl/audio_pkg.sv
// rtl/audio_pkg.sv - shared audio sample types and underrun policy constants
package audio_pkg;

    localparam int DW         = 16;
    localparam int FRAME_BITS = 2 * DW;

    typedef struct packed {
        logic [DW-1:0] left;
        logic [DW-1:0] right;
    } stereo_pair_t;

    localparam int UNDERRUN_ZEROS  = 0;
    localparam int UNDERRUN_REPEAT = 1;

endpackage

// File: rtl/aud_pair_fifo.sv
// rtl/aud_pair_fifo.sv - synchronous DEPTH-entry FIFO of stereo sample pairs
module aud_pair_fifo
    import audio_pkg::*;
#(
    parameter int  DEPTH  = 4,
    parameter type pair_t = stereo_pair_t
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  pair_t                  wr_data,
    output pair_t                  rd_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    pair_t         mem_q [DEPTH];
    pair_t         mem_d [DEPTH];
    logic [PW-1:0] wr_q, wr_d;
    logic [PW-1:0] rd_q, rd_d;
    logic [LW-1:0] lvl_q, lvl_d;
    logic          do_push;
    logic          do_pop;

    assign full    = (lvl_q == LW'(DEPTH));
    assign empty   = (lvl_q == '0);
    assign level   = lvl_q;
    assign rd_data = mem_q[rd_q];

    always_comb begin
        mem_d   = mem_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        lvl_d   = lvl_q;
        do_push = push && !full;
        do_pop  = pop && !empty;
        // Pointers wrap naturally because DEPTH is a power of two.
        if (do_push) begin
            mem_d[wr_q] = wr_data;
            wr_d        = wr_q + 1'b1;
        end
        if (do_pop) begin
            rd_d = rd_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   lvl_d = lvl_q + 1'b1;
            2'b01:   lvl_d = lvl_q - 1'b1;
            default: lvl_d = lvl_q;
        endcase
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
        if (reset) begin
            wr_q  <= '0;
            rd_q  <= '0;
            lvl_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            lvl_q <= lvl_d;
        end
    end

endmodule

// File: rtl/aud_dac_frame_tx.sv
// rtl/aud_dac_frame_tx.sv - DSP-mode stereo DAC serializer; AUD_DAC_UNDERRUN_CNT_EN enables underrun_cnt
module aud_dac_frame_tx #(
    parameter int DW            = audio_pkg::DW,
    parameter int DEPTH         = 4,
    parameter int UNDERRUN_HOLD = 1
) (
    input  logic                   AUD_BCLK,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DW-1:0]          in_left,
    input  logic [DW-1:0]          in_right,
    input  logic                   AUD_DACLRCK,
    output logic                   AUD_DACDAT,
    output logic [$clog2(DEPTH):0] fifo_level,
    output logic                   underrun,
    output logic [15:0]            underrun_cnt
);
    import audio_pkg::*;

    localparam int FB = 2 * DW;
    localparam int CW = $clog2(FB + 1);
    localparam logic [CW-1:0] CNT_IDLE = CW'(FB);

    typedef logic [FB-1:0] word_t;

    logic          lrck_q, lrck_d;
    word_t         shift_q, shift_d;
    word_t         last_q, last_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          dacdat_q, dacdat_d;
    logic          fs;
    logic          push;
    logic          pop;
    logic          fifo_full;
    logic          fifo_empty;
    word_t         pop_data;

    assign in_ready   = !reset && !fifo_full;
    assign push       = in_valid && in_ready;
    assign fs         = AUD_DACLRCK && !lrck_q;
    assign pop        = fs && !fifo_empty;
    assign underrun   = fs && fifo_empty && !reset;
    assign AUD_DACDAT = dacdat_q;

    aud_pair_fifo #(
        .DEPTH  (DEPTH),
        .pair_t (word_t)
    ) u_fifo (
        .clk     (AUD_BCLK),
        .reset   (reset),
        .push    (push),
        .pop     (pop),
        .wr_data ({in_left, in_right}),
        .rd_data (pop_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    always_comb begin
        lrck_d   = AUD_DACLRCK;
        shift_d  = shift_q;
        last_d   = last_q;
        cnt_d    = cnt_q;
        dacdat_d = (cnt_q < CNT_IDLE) && shift_q[FB-1];
        // A new sync always restarts the frame, even mid-frame.
        if (fs) begin
            cnt_d = '0;
            if (!fifo_empty) begin
                shift_d = pop_data;
                last_d  = pop_data;
            end else if (UNDERRUN_HOLD == UNDERRUN_REPEAT) begin
                shift_d = last_q;
            end else begin
                shift_d = '0;
            end
        end else if (cnt_q < CNT_IDLE) begin
            shift_d = {shift_q[FB-2:0], 1'b0};
            cnt_d   = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge AUD_BCLK) begin
        if (reset) begin
            lrck_q  <= 1'b0;
            shift_q <= '0;
            last_q  <= '0;
            cnt_q   <= '0;
        end else begin
            lrck_q  <= lrck_d;
            shift_q <= shift_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    // Falling-edge retime keeps DACDAT stable around the codec's rising-edge sample.
    always_ff @(negedge AUD_BCLK) begin
        if (reset) begin
            dacdat_q <= 1'b0;
        end else begin
            dacdat_q <= dacdat_d;
        end
    end

`ifdef AUD_DAC_UNDERRUN_CNT_EN
    logic [15:0] ucnt_q, ucnt_d;

    always_comb begin
        ucnt_d = ucnt_q;
        if (underrun && (ucnt_q != 16'hFFFF)) begin
            ucnt_d = ucnt_q + 16'd1;
        end
    end

    always_ff @(posedge AUD_BCLK) begin
        if (reset) begin
            ucnt_q <= '0;
        end else begin
            ucnt_q <= ucnt_d;
        end
    end

    assign underrun_cnt = ucnt_q;
`else
    assign underrun_cnt = '0;
`endif

endmodule
